mdu_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the pipelined CPU, sitting in EX beside the combinational ALU.
- Accepts one operation per start pulse, holds the HI/LO architectural registers, and raises busy for a fixed, op-dependent latency.
- The hazard unit stalls the pipeline on (mdu_start | mdu_busy) for any instruction that touches HI/LO.
- Adds accumulate modes (MADD/MSUB) and width generality, which the ALU lacks.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_arith.sv | 122 ++++++++++++
 rtl/mdu_unit.sv | 145 ++++++++++++++
 tb/tb_mdu_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// FSM encoding and default latencies.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

    localparam int unsigned MDU_MUL_LAT_DEF = 5;
    localparam int unsigned MDU_DIV_LAT_DEF = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Accumulating multiplies read the current {HI,LO}.
    function automatic logic is_acc_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result generator: given an op, operands and the current
// {HI,LO}, produce the next {HI,LO} and whether it should be written.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          EN_ACC = 1'b1
) (
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    hi,
    input  logic [WIDTH-1:0]    lo,
    output logic [WIDTH-1:0]    next_hi_c,
    output logic [WIDTH-1:0]    next_lo_c,
    output logic                wr_en_c
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0]    acc;
    logic [DW-1:0]    prod_s;
    logic [DW-1:0]    prod_u;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] bu_div;
    logic [WIDTH-1:0] qu;
    logic [WIDTH-1:0] ru;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] qm;
    logic [WIDTH-1:0] rm;
    logic [WIDTH-1:0] qs;
    logic [WIDTH-1:0] rs;

    assign acc    = {hi, lo};
    assign prod_u = DW'(a) * DW'(b);
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    // Divisor forced to 1 when zero so the divider never sees x/0; the
    // result is discarded in that case anyway.
    assign b_zero = (b == '0);
    assign bu_div = b_zero ? WIDTH'(1) : b;
    assign qu     = a / bu_div;
    assign ru     = a % bu_div;

    // Signed divide on magnitudes; most-negative / -1 wraps back to
    // most-negative with a zero remainder without special casing.
    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_zero ? WIDTH'(1) : (b_neg ? -b : b);
    assign qm    = a_mag / b_mag;
    assign rm    = a_mag % b_mag;
    assign qs    = (a_neg ^ b_neg) ? -qm : qm;
    assign rs    = a_neg ? -rm : rm;

    always_comb begin
        next_hi_c = hi;
        next_lo_c = lo;
        wr_en_c   = 1'b0;
        case (op)
            MDU_MULT: begin
                {next_hi_c, next_lo_c} = prod_s;
                wr_en_c                = 1'b1;
            end
            MDU_MULTU: begin
                {next_hi_c, next_lo_c} = prod_u;
                wr_en_c                = 1'b1;
            end
            MDU_DIV: begin
                if (!b_zero) begin
                    next_hi_c = rs;
                    next_lo_c = qs;
                    wr_en_c   = 1'b1;
                end
            end
            MDU_DIVU: begin
                if (!b_zero) begin
                    next_hi_c = ru;
                    next_lo_c = qu;
                    wr_en_c   = 1'b1;
                end
            end
            MDU_MTHI: begin
                next_hi_c = a;
                wr_en_c   = 1'b1;
            end
            MDU_MTLO: begin
                next_lo_c = a;
                wr_en_c   = 1'b1;
            end
            MDU_MADD: begin
                if (EN_ACC) begin
                    {next_hi_c, next_lo_c} = acc + prod_s;
                    wr_en_c                = 1'b1;
                end
            end
            MDU_MADDU: begin
                if (EN_ACC) begin
                    {next_hi_c, next_lo_c} = acc + prod_u;
                    wr_en_c                = 1'b1;
                end
            end
            MDU_MSUB: begin
                if (EN_ACC) begin
                    {next_hi_c, next_lo_c} = acc - prod_s;
                    wr_en_c                = 1'b1;
                end
            end
            MDU_MSUBU: begin
                if (EN_ACC) begin
                    {next_hi_c, next_lo_c} = acc - prod_u;
                    wr_en_c                = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO. The result is computed at
// the start edge, held in pending registers and committed after LAT cycles.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = MDU_MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = MDU_DIV_LAT_DEF,
    parameter bit          EN_ACC  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mdu_start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [WIDTH-1:0]    mdu_opA,
    input  logic [WIDTH-1:0]    mdu_opB,
    output logic                mdu_busy,
    output logic [WIDTH-1:0]    HI,
    output logic [WIDTH-1:0]    LO
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pend_hi_q;
    logic [WIDTH-1:0] pend_lo_q;
    logic             pend_we_q;

    logic [WIDTH-1:0] arith_hi_c;
    logic [WIDTH-1:0] arith_lo_c;
    logic             arith_we_c;

    logic             is_mul_c;
    logic             is_div_c;
    logic             is_mt_c;
    logic [CNT_W-1:0] lat_cnt_c;
    logic             launch_c;
    logic             mt_wr_c;
    logic             commit_c;

    mdu_arith #(
        .WIDTH  (WIDTH),
        .EN_ACC (EN_ACC)
    ) u_arith (
        .op        (mdu_op),
        .a         (mdu_opA),
        .b         (mdu_opB),
        .hi        (HI),
        .lo        (LO),
        .next_hi_c (arith_hi_c),
        .next_lo_c (arith_lo_c),
        .wr_en_c   (arith_we_c)
    );

    // Op classification; disabled accumulate ops fall through as NOP.
    always_comb begin
        is_mul_c  = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU) ||
                    (EN_ACC && is_acc_op(mdu_op));
        is_div_c  = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
        is_mt_c   = (mdu_op == MDU_MTHI) || (mdu_op == MDU_MTLO);
        lat_cnt_c = is_div_c ? DIV_CNT : MUL_CNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mdu_start && (is_mul_c || is_div_c)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests are only honoured in IDLE; anything arriving in RUN is dropped.
    always_comb begin
        launch_c = 1'b0;
        mt_wr_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                launch_c = mdu_start && (is_mul_c || is_div_c);
                mt_wr_c  = mdu_start && is_mt_c;
            end
            ST_RUN: begin
                commit_c = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
            mdu_busy  <= 1'b0;
        end else if (launch_c) begin
            cnt_q     <= lat_cnt_c;
            pend_hi_q <= arith_hi_c;
            pend_lo_q <= arith_lo_c;
            pend_we_q <= arith_we_c;
            mdu_busy  <= 1'b1;
        end else if (commit_c) begin
            mdu_busy  <= 1'b0;
        end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
            cnt_q     <= cnt_q - CNT_W'(1);
        end
    end

    // Architectural HI/LO: immediate moves or a deferred commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (mt_wr_c) begin
            HI <= arith_hi_c;
            LO <= arith_lo_c;
        end else if (commit_c && pend_we_q) begin
            HI <= pend_hi_q;
            LO <= pend_lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized scoreboard bench for mdu_unit: a behavioural HI/LO model queues
// expected commits by cycle, and a negedge monitor compares busy/HI/LO.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        mdu_start = 1'b0;
    logic [3:0]  mdu_op    = 4'd0;
    logic [31:0] mdu_opA   = 32'd0;
    logic [31:0] mdu_opB   = 32'd0;
    logic        mdu_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    logic        rst1 = 1'b1;
    logic        st1  = 1'b0;
    logic [3:0]  op1  = 4'd0;
    logic [31:0] a1   = 32'd0;
    logic [31:0] b1   = 32'd0;
    logic        busy1;
    logic [31:0] hi1;
    logic [31:0] lo1;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          armed    = 1'b0;
    int          b_lo     = 1;
    int          b_hi     = 0;
    logic [31:0] arch_hi  = 32'd0;
    logic [31:0] arch_lo  = 32'd0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    mdu_unit #(
        .WIDTH   (32),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .EN_ACC  (1'b1)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .mdu_opA   (mdu_opA),
        .mdu_opB   (mdu_opB),
        .mdu_busy  (mdu_busy),
        .HI        (HI),
        .LO        (LO)
    );

    mdu_unit #(
        .WIDTH   (32),
        .MUL_LAT (1),
        .DIV_LAT (3),
        .EN_ACC  (1'b0)
    ) u_dut1 (
        .clk       (clk),
        .reset     (rst1),
        .mdu_start (st1),
        .mdu_op    (op1),
        .mdu_opA   (a1),
        .mdu_opB   (b1),
        .mdu_busy  (busy1),
        .HI        (hi1),
        .LO        (lo1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // Architectural model: what HI/LO become and when, from the op definitions.
    task automatic model_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          lat;
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] qv;
        logic [63:0] rv;
        logic [63:0] ps;
        logic [63:0] pu;
        logic [63:0] acc;
        logic [63:0] t;
        n = cyc;
        if (n >= b_lo && n <= b_hi) return;
        sa  = $signed(a);
        sb  = $signed(b);
        ps  = sa * sb;
        pu  = {32'd0, a} * {32'd0, b};
        acc = {arch_hi, arch_lo};
        t   = acc;
        lat = 0;
        case (op)
            MDU_MULT:  begin t = ps;       lat = MUL_LAT; end
            MDU_MULTU: begin t = pu;       lat = MUL_LAT; end
            MDU_MADD:  begin t = acc + ps; lat = MUL_LAT; end
            MDU_MADDU: begin t = acc + pu; lat = MUL_LAT; end
            MDU_MSUB:  begin t = acc - ps; lat = MUL_LAT; end
            MDU_MSUBU: begin t = acc - pu; lat = MUL_LAT; end
            MDU_DIV: begin
                lat = DIV_LAT;
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    qv = sq;
                    rv = sr;
                    t  = {rv[31:0], qv[31:0]};
                end
            end
            MDU_DIVU: begin
                lat = DIV_LAT;
                if (b != 32'd0) t = {a % b, a / b};
            end
            MDU_MTHI: t = {a, arch_lo};
            MDU_MTLO: t = {arch_hi, a};
            default:  return;
        endcase
        arch_hi = t[63:32];
        arch_lo = t[31:0];
        if (lat == 0) begin
            exp_q.push_back(exp_t'{due: n + 1, hi: arch_hi, lo: arch_lo});
        end else begin
            exp_q.push_back(exp_t'{due: n + 1 + lat, hi: arch_hi, lo: arch_lo});
            b_lo = n + 1;
            b_hi = n + lat;
        end
    endtask

    task automatic drive(input bit st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mdu_start = st;
        mdu_op    = op;
        mdu_opA   = a;
        mdu_opB   = b;
        if (st) model_start(op, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, MDU_NOP, 32'd0, 32'd0);
    endtask

    // One-cycle reset pulse; any op still in flight is aborted.
    task automatic do_reset();
        int n;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mdu_start = 1'b0;
        n         = cyc;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].due > n) exp_q.delete(i);
        exp_q.push_back(exp_t'{due: n + 1, hi: 32'd0, lo: 32'd0});
        if (b_hi > n) b_hi = n;
        arch_hi = 32'd0;
        arch_lo = 32'd0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 9));
            4:       v = -32'($urandom_range(1, 9));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due == cyc) begin
                    m_hi = exp_q[i].hi;
                    m_lo = exp_q[i].lo;
                    exp_q.delete(i);
                end
            end
            check("busy", 32'(mdu_busy), (cyc >= b_lo && cyc <= b_hi) ? 32'd1 : 32'd0);
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rst1  = 1'b0;
        armed = 1'b1;

        drive(1'b1, MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        idle(MUL_LAT + 1);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        drive(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MUL_LAT + 1);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        drive(1'b1, MDU_DIV, -32'd7, 32'd2);
        idle(DIV_LAT + 1);
        check("div_hi", HI, 32'hFFFF_FFFF);
        check("div_lo", LO, 32'hFFFF_FFFD);

        drive(1'b1, MDU_DIVU, 32'd7, 32'd0);
        idle(DIV_LAT + 1);
        check("divz_hi", HI, 32'hFFFF_FFFF);
        check("divz_lo", LO, 32'hFFFF_FFFD);

        drive(1'b1, MDU_MTHI, 32'h1234_5678, 32'd0);
        drive(1'b1, MDU_MTLO, 32'd0, 32'd0);
        drive(1'b1, MDU_MADD, 32'd2, 32'd3);
        idle(MUL_LAT + 1);
        check("madd_hi", HI, 32'h1234_5678);
        check("madd_lo", LO, 32'd6);
        drive(1'b1, MDU_MSUB, 32'd1, 32'd7);
        idle(MUL_LAT + 1);
        check("msub_hi", HI, 32'h1234_5677);
        check("msub_lo", LO, 32'hFFFF_FFFF);

        drive(1'b1, MDU_DIV, 32'd100, 32'd7);
        idle(2);
        drive(1'b1, MDU_MTLO, 32'h0000_00AA, 32'd0);
        idle(DIV_LAT - 2);
        check("ign_hi", HI, 32'd2);
        check("ign_lo", LO, 32'd14);

        drive(1'b1, MDU_DIV, 32'd100, 32'd7);
        idle(3);
        do_reset();
        idle(DIV_LAT + 2);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", 32'(mdu_busy), 32'd0);

        drive(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_LAT + 1);
        check("ovf_hi", HI, 32'd0);
        check("ovf_lo", LO, 32'h8000_0000);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else drive($urandom_range(0, 5) != 0, 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 11));
        end
        idle(DIV_LAT + 2);

        // Single-cycle multiply latency and accumulate ops disabled.
        @(posedge clk);
        #1;
        st1 = 1'b1; op1 = MDU_MULT; a1 = 32'd3; b1 = 32'd4;
        @(negedge clk);
        check("l1_busy_pre", 32'(busy1), 32'd0);
        @(posedge clk);
        #1;
        st1 = 1'b0;
        @(negedge clk);
        check("l1_busy_on", 32'(busy1), 32'd1);
        check("l1_lo_hold", lo1, 32'd0);
        @(negedge clk);
        check("l1_busy_off", 32'(busy1), 32'd0);
        check("l1_hi", hi1, 32'd0);
        check("l1_lo", lo1, 32'd12);
        @(posedge clk);
        #1;
        st1 = 1'b1; op1 = MDU_MADD;
        @(posedge clk);
        #1;
        st1 = 1'b0;
        @(negedge clk);
        check("noacc_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        check("noacc_lo", lo1, 32'd12);

        idle(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
